// File: rtl/btn_debounce_multi.sv
// Purpose     : synchronise, debounce and edge-detect N_CH push buttons, with optional hold-to-repeat strobes.
// Latency     : an input first sampled on edge k and held moves level_o/press_o/release_o after edge k+STABLE_CYC+1.
// Backpressure: none; every strobe is a single-cycle pulse that the consumer must take when it is asserted.
// Ports: clk; rst_n (async, active-low); btn_in[N_CH] raw buttons;
//        level_o / press_o / release_o / repeat_o [N_CH] per channel; any_press_o = OR of press_o|repeat_o.
module btn_debounce_multi #(
  parameter int N_CH         = 4,
  parameter bit ACTIVE_LOW   = 1'b0,
  parameter int STABLE_CYC   = 50000,
  parameter int CNT_W        = 16,
  parameter bit REPEAT_EN    = 1'b1,
  parameter int REPEAT_DELAY = 5000000,
  parameter int REPEAT_RATE  = 1000000,
  parameter int RPT_W        = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] repeat_o,
  output logic            any_press_o
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST   = RPT_W'(REPEAT_RATE - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             differ, accept;

    // Polarity is normalised before the synchroniser so everything downstream is 1 = pressed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        level_q   <= 1'b0;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1_q      <= btn_in[i] ^ ACTIVE_LOW;
        s2_q      <= s1_q;
        level_q   <= level_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Count consecutive cycles where the synchronised input disagrees with the accepted level;
    // any agreement restarts the count, and acceptance clears it so it can never wrap.
    always_comb begin
      differ    = (s2_q != level_q);
      accept    = differ && (cnt_q == STABLE_LAST);
      cnt_d     = '0;
      if (differ && !accept) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      level_d   = level_q ^ accept;
      press_d   = accept & ~level_q;
      release_d = accept & level_q;
    end

    assign level_o[i]   = level_q;
    assign press_o[i]   = press_q;
    assign release_o[i] = release_q;

    if (REPEAT_EN) begin : g_rpt
      logic             first_q, first_d;
      logic [RPT_W-1:0] rcnt_q, rcnt_d;
      logic             rpt_q, rpt_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          first_q <= 1'b0;
          rcnt_q  <= '0;
          rpt_q   <= 1'b0;
        end else begin
          first_q <= first_d;
          rcnt_q  <= rcnt_d;
          rpt_q   <= rpt_d;
        end
      end

      // first selects the long initial delay; after the first strobe the shorter rate applies.
      // The press cycle itself only arms the counter (level_q is still 0), so a repeat can
      // never coincide with press_o, and the release cycle suppresses any pending strobe.
      always_comb begin
        first_d = first_q;
        rcnt_d  = rcnt_q;
        rpt_d   = 1'b0;
        if (press_d) begin
          first_d = 1'b1;
          rcnt_d  = '0;
        end else if (!level_q || release_d) begin
          first_d = 1'b0;
          rcnt_d  = '0;
        end else if (first_q && (rcnt_q == DELAY_LAST)) begin
          rpt_d   = 1'b1;
          first_d = 1'b0;
          rcnt_d  = '0;
        end else if (!first_q && (rcnt_q == RATE_LAST)) begin
          rpt_d   = 1'b1;
          rcnt_d  = '0;
        end else begin
          rcnt_d  = rcnt_q + RPT_W'(1);
        end
      end

      assign repeat_o[i] = rpt_q;
    end else begin : g_no_rpt
      assign repeat_o[i] = 1'b0;
    end
  end

  assign any_press_o = |(press_o | repeat_o);

endmodule
